// File: rtl/jtag_tap_controller.sv
// JTAG TAP controller: 16-state TMS-driven FSM, 4-bit instruction register,
// 1-bit bypass register and the TDO mux.
`timescale 1ns/1ps
module jtag_tap_controller #(
    parameter logic [3:0] IR_RESET   = 4'b0001,
    parameter logic [3:0] IR_CAPTURE = 4'b0101,
    parameter logic [3:0] INSTR_USER = 4'b0010
) (
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       idcode_tdo,
    input  logic       user_tdo,
    output logic [3:0] tap_state,
    output logic [3:0] IR,
    output logic       TDO,
    output logic       TDO_EN
);

    typedef enum logic [3:0] {
        EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
        EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
        RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
    } tap_state_t;

    tap_state_t state_reg;
    logic [3:0] ir_reg;
    logic [3:0] ir_shift_reg;
    logic       bypass_reg;
    logic       bypass_sel;

    assign bypass_sel = (ir_reg != IR_RESET) && (ir_reg != INSTR_USER);

    // Register actions key on the state present at the edge, before the transition.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_reg    <= TLR;
            ir_reg       <= IR_RESET;
            ir_shift_reg <= '0;
            bypass_reg   <= 1'b0;
        end else begin
            case (state_reg)
                TLR:      state_reg <= TMS ? TLR      : RTI;
                RTI:      state_reg <= TMS ? SEL_DR   : RTI;
                SEL_DR:   state_reg <= TMS ? SEL_IR   : CAP_DR;
                CAP_DR:   state_reg <= TMS ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: state_reg <= TMS ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: state_reg <= TMS ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_reg <= TMS ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: state_reg <= TMS ? UPD_DR   : SHIFT_DR;
                UPD_DR:   state_reg <= TMS ? SEL_DR   : RTI;
                SEL_IR:   state_reg <= TMS ? TLR      : CAP_IR;
                CAP_IR:   state_reg <= TMS ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: state_reg <= TMS ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: state_reg <= TMS ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_reg <= TMS ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: state_reg <= TMS ? UPD_IR   : SHIFT_IR;
                UPD_IR:   state_reg <= TMS ? SEL_DR   : RTI;
                default:  state_reg <= TLR;
            endcase

            case (state_reg)
                TLR: begin
                    ir_reg       <= IR_RESET;
                    ir_shift_reg <= '0;
                end
                CAP_IR:   ir_shift_reg <= IR_CAPTURE;
                SHIFT_IR: ir_shift_reg <= {TDI, ir_shift_reg[3:1]};
                UPD_IR:   ir_reg       <= ir_shift_reg;
                CAP_DR:   if (bypass_sel) bypass_reg <= 1'b0;
                SHIFT_DR: if (bypass_sel) bypass_reg <= TDI;
                default: ;
            endcase
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state_reg == SHIFT_IR) begin
            TDO = ir_shift_reg[0];
        end else if (state_reg == SHIFT_DR) begin
            if (ir_reg == IR_RESET)
                TDO = idcode_tdo;
            else if (ir_reg == INSTR_USER)
                TDO = user_tdo;
            else
                TDO = bypass_reg;
        end
    end

    assign TDO_EN    = (state_reg == SHIFT_DR) || (state_reg == SHIFT_IR);
    assign tap_state = state_reg;
    assign IR        = ir_reg;

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
IEEE 1149.1-style TAP controller and instruction register that sequence the die's JTAG data registers (IDCODE, BYPASS, USER).
- Decodes TMS into the 16-state TAP FSM and drives tap_state/IR to the data-register blocks.
- Holds the 4-bit instruction register and the 1-bit bypass register.
- Muxes the selected register's serial output onto TDO.

Parameters:
IR_RESET, 4'b0001, instruction loaded in Test-Logic-Reset (IDCODE)
IR_CAPTURE, 4'b0101, pattern loaded into IR shift stage in Capture-IR (LSBs 01 per 1149.1)
INSTR_USER, 4'b0010, opcode selecting user_tdo

Ports:
TCK  input  1  JTAG clock; all state on posedge TCK
TRST_N  input  1  asynchronous active-low reset
TMS  input  1  test mode select, sampled on posedge TCK
TDI  input  1  serial data in
idcode_tdo  input  1  serial out of IDCODE data register
user_tdo  input  1  serial out of USER data register
tap_state  output  4  current TAP state (encoding below)
IR  output  4  active (updated) instruction
TDO  output  1  serial data out (combinational mux)
TDO_EN  output  1  high only in SHIFT_DR / SHIFT_IR

Behaviour:
- Interface: one clock, TCK; reset TRST_N is asynchronous, active-low.
- State encoding:
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPD_DR=5.
  - SEL_IR=4, CAP_IR=E, SHIFT_IR=A, EXIT1_IR=9, PAUSE_IR=B, EXIT2_IR=8, UPD_IR=D.
- Transitions (TMS=0 / TMS=1):
  - TLR→RTI/TLR; RTI→RTI/SEL_DR; SEL_DR→CAP_DR/SEL_IR; SEL_IR→CAP_IR/TLR.
  - CAP_x→SHIFT_x/EXIT1_x; SHIFT_x→SHIFT_x/EXIT1_x; EXIT1_x→PAUSE_x/UPD_x.
  - PAUSE_x→PAUSE_x/EXIT2_x; EXIT2_x→SHIFT_x/UPD_x; UPD_x→RTI/SEL_DR.
  - Five consecutive TMS=1 edges reach TLR from any state.
- Reset (TRST_N=0, async): tap_state=F, IR=IR_RESET, ir_shift=0, bypass_reg=0. Outputs: TDO_EN=0, TDO=bypass_reg=0.
- All register actions below are keyed on the tap_state value present at the posedge (pre-transition), the same convention the data registers use:
  - TLR: IR<=IR_RESET; ir_shift<=0.
  - CAP_IR: ir_shift<=IR_CAPTURE.
  - SHIFT_IR: ir_shift<={TDI, ir_shift[3:1]} (LSB first).
  - UPD_IR: IR<=ir_shift. IR is unchanged in every other state, including Pause/Exit.
  - CAP_DR with bypass selected: bypass_reg<=0.
  - SHIFT_DR with bypass selected: bypass_reg<=TDI.
- Bypass is selected when IR is neither IR_RESET (IDCODE) nor INSTR_USER. This includes 4'b1111 and all undefined opcodes.
- TDO mux (combinational):
  - SHIFT_IR: ir_shift[0].
  - SHIFT_DR: idcode_tdo if IR==0001, user_tdo if IR==INSTR_USER, else bypass_reg.
  - Otherwise: 0.
- TDO_EN = (tap_state==SHIFT_DR) || (tap_state==SHIFT_IR).
- Latency:
  - tap_state updates one posedge after TMS is sampled.
  - IR change is visible the cycle after the UPD_IR edge.
  - Bypass path is one TCK from TDI to TDO.
- TRST_N asserted mid-shift: immediately aborts to TLR and discards ir_shift; IR returns to IDCODE.

Test Plan:
- TRST_N pulse low mid SHIFT_IR (ir_shift partly loaded) -> same cycle tap_state=4'hF, IR=4'b0001, TDO_EN=0.
- From RTI, TMS=1,1,1,1,1 -> states 7,4,F,F,F. From SHIFT_DR, five TMS=1 -> TLR.
- IR scan: TMS path to SHIFT_IR, shift TDI=0,1,0,0 (LSB first) with TMS=1 on the last bit, then UPD_IR:
  - TDO during the shift = 1,0,1,0 (captured 0101).
  - IR=4'b0010 after UPD_IR; subsequent SHIFT_DR routes user_tdo to TDO.
- Reset then DR scan: with an IDCODE register (die_id=32'h1234_5A5B) attached, CAP_DR then 32 SHIFT_DR clocks -> TDO bit sequence equals 0x12345A5B LSB first (1,1,0,1,...).
- Load IR=4'b1111, shift DR with TDI=1,0,1,1 -> TDO=0 (captured), then 1,0,1 delayed one TCK.
- Pause/resume: SHIFT_IR, 2 bits shifted, EXIT1→PAUSE (3 clocks)→EXIT2→SHIFT_IR, 2 more bits -> ir_shift holds during PAUSE; final IR equals the 4 TDI bits.
